// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encodings, the width of
// the re-sequence counter, and a saturating-increment helper.
package reset_sequencer_pkg;

   // Encodings are visible through the status register; keep them stable.
   typedef enum logic [1:0] {
      ST_HOLD      = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam int unsigned RCW = 8;
   localparam logic [RCW-1:0] RC_MAX = '1;

   // Increment that sticks at all-ones.
   function automatic logic [RCW-1:0] sat_inc(input logic [RCW-1:0] v);
      return (v == RC_MAX) ? v : v + RCW'(1);
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its environment.
//   lock_in      : asynchronous lock status (master -> sequencer)
//   force_reset  : synchronous re-sequence request (master -> sequencer)
//   rst_out      : active-high reset lines, bit 0 released first
//   done         : all lines released
//   state        : current sequencer state encoding
//   retrig_count : saturating re-sequence count
interface reset_sequencer_if
   import reset_sequencer_pkg::*;
   #(parameter int unsigned NOUT = 4);

   logic            lock_in;
   logic            force_reset;
   logic [NOUT-1:0] rst_out;
   logic            done;
   logic [1:0]      state;
   logic [RCW-1:0]  retrig_count;

   modport master (
      output lock_in, force_reset,
      input  rst_out, done, state, retrig_count
   );

   modport slave (
      input  lock_in, force_reset,
      output rst_out, done, state, retrig_count
   );

endinterface

// File: rtl/reset_sequencer_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level, cleared to 0 by
// the asynchronous active-low reset.
//   clk    : destination clock
//   nreset : asynchronous active-low clear
//   d      : asynchronous input
//   q      : synchronised output
module reset_sequencer_sync_bit (
   input  logic clk,
   input  logic nreset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-output reset sequencer. Holds every reset line asserted for a
// power-up interval, waits for a filtered clock-lock indication, then
// releases the lines one at a time in index order with a fixed spacing.
// Lock loss (in RELEASE/RUN) or a software request re-runs the sequence
// and bumps a saturating counter.
//   clk    : sequencer clock (TCXO domain)
//   nreset : asynchronous active-low reset
//   bus    : slave side of reset_sequencer_if (lock_in, force_reset in;
//            rst_out, done, state, retrig_count out, all registered)
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned NOUT         = 4,
   parameter int unsigned CW           = 24,
   parameter int unsigned HOLD_CYCLES  = 16000000,
   parameter int unsigned STAGE_CYCLES = 65536,
   parameter int unsigned LOCK_FILTER  = 16,
   parameter int unsigned USE_LOCK     = 1
) (
   input  logic               clk,
   input  logic               nreset,
   reset_sequencer_if.slave   bus
);

   localparam int unsigned IW = (NOUT > 1) ? $clog2(NOUT) : 1;
   localparam int unsigned LW = $clog2(LOCK_FILTER + 1);

   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILTER - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NOUT - 1);

   state_t          state_q;
   logic [NOUT-1:0] rst_q;
   logic            done_q;
   logic [RCW-1:0]  count_q;
   logic [CW-1:0]   hcnt;
   logic [CW-1:0]   scnt;
   logic [LW-1:0]   lcnt;
   logic [IW-1:0]   idx;
   logic            lock_s;
   logic            retrig;

   // Lock qualification source; tied high when lock is not used.
   generate
      if (USE_LOCK != 0) begin : g_lock
         reset_sequencer_sync_bit u_sync (
            .clk    (clk),
            .nreset (nreset),
            .d      (bus.lock_in),
            .q      (lock_s)
         );
      end else begin : g_nolock
         assign lock_s = 1'b1;
      end
   endgenerate

   // Lock loss only retriggers once lines have started releasing; in
   // WAIT_LOCK it merely restarts the filter. Both sources count once.
   assign retrig = (state_q != ST_HOLD) &&
                   (bus.force_reset ||
                    ((USE_LOCK != 0) && !lock_s &&
                     ((state_q == ST_RELEASE) || (state_q == ST_RUN))));

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_HOLD;
         rst_q   <= '1;
         done_q  <= 1'b0;
         count_q <= '0;
         hcnt    <= '0;
         scnt    <= '0;
         lcnt    <= '0;
         idx     <= '0;
      end else if (retrig) begin
         state_q <= ST_HOLD;
         rst_q   <= '1;
         done_q  <= 1'b0;
         hcnt    <= '0;
         count_q <= sat_inc(count_q);
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (bus.force_reset) begin
                  hcnt <= '0;
               end else if (hcnt == HOLD_LAST) begin
                  state_q <= ST_WAIT_LOCK;
                  hcnt    <= '0;
                  lcnt    <= '0;
               end else begin
                  hcnt <= hcnt + CW'(1);
               end
            end

            ST_WAIT_LOCK: begin
               if (!lock_s) begin
                  lcnt <= '0;
               end else if (lcnt == LOCK_LAST) begin
                  rst_q[0] <= 1'b0;
                  lcnt     <= '0;
                  scnt     <= '0;
                  if (NOUT == 1) begin
                     state_q <= ST_RUN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RELEASE;
                     idx     <= IW'(1);
                  end
               end else begin
                  lcnt <= lcnt + LW'(1);
               end
            end

            ST_RELEASE: begin
               if (scnt == STAGE_LAST) begin
                  rst_q[idx] <= 1'b0;
                  scnt       <= '0;
                  if (idx == IDX_LAST) begin
                     state_q <= ST_RUN;
                     done_q  <= 1'b1;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end else begin
                  scnt <= scnt + CW'(1);
               end
            end

            default: begin
               // ST_RUN: outputs hold until a retrigger.
            end
         endcase
      end
   end

   assign bus.rst_out      = rst_q;
   assign bus.done         = done_q;
   assign bus.state        = state_q;
   assign bus.retrig_count = count_q;

endmodule
